// File: rtl/ethernet_rx_slot_buffer.sv
// ethernet_rx_slot_buffer: multi-slot RX frame ring between the MAC AXI-Stream output and MMIO reads,
// discarding bad, oversize and no-room frames in hardware and counting them.
module ethernet_rx_slot_buffer #(
   parameter int data_width_p  = 32,
   parameter int eth_mtu_p     = 2048,
   parameter int slots_p       = 4,
   parameter int count_width_p = 16,
   localparam int size_width_lp = $clog2(eth_mtu_p + 1),
   localparam int addr_width_lp = $clog2(eth_mtu_p),
   localparam int slot_width_lp = $clog2(slots_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [data_width_p-1:0]  rx_axis_tdata_i,
   input  logic [data_width_p/8-1:0] rx_axis_tkeep_i,
   input  logic                     rx_axis_tvalid_i,
   output logic                     rx_axis_tready_o,
   input  logic                     rx_axis_tlast_i,
   input  logic                     rx_axis_tuser_i,
   output logic                     packet_avail_o,
   output logic [size_width_lp-1:0] packet_rsize_o,
   input  logic                     packet_rvalid_i,
   input  logic [addr_width_lp-1:0] packet_raddr_i,
   output logic [data_width_p-1:0]  packet_rdata_o,
   input  logic                     packet_ack_i,
   output logic [slot_width_lp:0]   pending_count_o,
   output logic [count_width_p-1:0] drop_full_count_o,
   output logic [count_width_p-1:0] drop_bad_count_o
);
   localparam int keep_w_lp = data_width_p / 8;
   localparam int lane_w_lp = $clog2(keep_w_lp);
   localparam int word_w_lp = addr_width_lp - lane_w_lp;
   localparam int sum_w_lp  = size_width_lp + 1;
   localparam logic [slot_width_lp:0] slots_lp = (slot_width_lp + 1)'(slots_p);
   localparam logic [sum_w_lp-1:0]    mtu_lp   = sum_w_lp'(eth_mtu_p);

   typedef enum logic [1:0] {IDLE, RECV, DROP} state_e;

   state_e                     state_q, state_d;
   logic [slot_width_lp-1:0]   head_q, head_d, tail_q, tail_d;
   logic [slot_width_lp:0]     pending_q, pending_d;
   logic [size_width_lp-1:0]   size_q [slots_p];
   logic [size_width_lp-1:0]   size_d [slots_p];
   logic [word_w_lp-1:0]       wcnt_q, wcnt_d, wr_word;
   logic [size_width_lp-1:0]   acc_q, acc_d;
   logic                       full_drop_q, full_drop_d;
   logic [count_width_p-1:0]   drop_full_q, drop_full_d, drop_bad_q, drop_bad_d;
   logic                       tready_q;
   logic [data_width_p-1:0]    rdata_q;
   logic [data_width_p-1:0]    mem_q [slots_p * (1 << word_w_lp)];
   logic [sum_w_lp-1:0]        pop, sum;
   logic                       beat, ack_ok, commit, inc_full, inc_bad, wr_en;

   assign beat   = rx_axis_tvalid_i & tready_q;
   assign ack_ok = packet_ack_i & (pending_q != '0);

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      acc_d       = acc_q;
      full_drop_d = full_drop_q;
      size_d      = size_q;
      wr_en       = 1'b0;
      wr_word     = '0;
      commit      = 1'b0;
      inc_full    = 1'b0;
      inc_bad     = 1'b0;
      pop         = '0;
      for (int i = 0; i < keep_w_lp; i++) pop = pop + sum_w_lp'(rx_axis_tkeep_i[i]);
      sum = {1'b0, acc_q} + pop;
      if (beat) begin
         case (state_q)
            IDLE: begin
               // The full decision is taken here only; a slot freed mid-drop never rescues the frame.
               if (pending_q == slots_lp) begin
                  inc_full    = rx_axis_tlast_i;
                  state_d     = rx_axis_tlast_i ? IDLE : DROP;
                  full_drop_d = 1'b1;
               end else begin
                  wr_en   = 1'b1;
                  acc_d   = size_width_lp'(pop);
                  wcnt_d  = word_w_lp'(1);
                  state_d = rx_axis_tlast_i ? IDLE : RECV;
                  inc_bad = rx_axis_tlast_i & rx_axis_tuser_i;
                  commit  = rx_axis_tlast_i & ~rx_axis_tuser_i;
                  if (commit) size_d[tail_q] = size_width_lp'(pop);
               end
            end
            RECV: begin
               if (sum > mtu_lp) begin
                  full_drop_d = 1'b0;
                  inc_bad     = rx_axis_tlast_i;
                  state_d     = rx_axis_tlast_i ? IDLE : DROP;
               end else begin
                  wr_en   = 1'b1;
                  wr_word = wcnt_q;
                  wcnt_d  = wcnt_q + word_w_lp'(1);
                  acc_d   = size_width_lp'(sum);
                  state_d = rx_axis_tlast_i ? IDLE : RECV;
                  inc_bad = rx_axis_tlast_i & rx_axis_tuser_i;
                  commit  = rx_axis_tlast_i & ~rx_axis_tuser_i;
                  if (commit) size_d[tail_q] = size_width_lp'(sum);
               end
            end
            DROP: begin
               inc_full = rx_axis_tlast_i & full_drop_q;
               inc_bad  = rx_axis_tlast_i & ~full_drop_q;
               state_d  = rx_axis_tlast_i ? IDLE : DROP;
            end
            default: state_d = IDLE;
         endcase
      end
      tail_d      = commit ? tail_q + slot_width_lp'(1) : tail_q;
      head_d      = ack_ok ? head_q + slot_width_lp'(1) : head_q;
      pending_d   = pending_q + (slot_width_lp + 1)'(commit) - (slot_width_lp + 1)'(ack_ok);
      drop_full_d = (inc_full && !(&drop_full_q)) ? drop_full_q + count_width_p'(1) : drop_full_q;
      drop_bad_d  = (inc_bad && !(&drop_bad_q)) ? drop_bad_q + count_width_p'(1) : drop_bad_q;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         head_q      <= '0;
         tail_q      <= '0;
         pending_q   <= '0;
         size_q      <= '{default: '0};
         wcnt_q      <= '0;
         acc_q       <= '0;
         full_drop_q <= 1'b0;
         drop_full_q <= '0;
         drop_bad_q  <= '0;
         tready_q    <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         pending_q   <= pending_d;
         size_q      <= size_d;
         wcnt_q      <= wcnt_d;
         acc_q       <= acc_d;
         full_drop_q <= full_drop_d;
         drop_full_q <= drop_full_d;
         drop_bad_q  <= drop_bad_d;
         tready_q    <= 1'b1;
         if (packet_rvalid_i) rdata_q <= mem_q[{head_q, packet_raddr_i[addr_width_lp-1:lane_w_lp]}];
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[{tail_q, wr_word}] <= rx_axis_tdata_i;
   end

   assign rx_axis_tready_o  = tready_q;
   assign packet_avail_o    = pending_q != '0;
   assign packet_rsize_o    = packet_avail_o ? size_q[head_q] : '0;
   assign packet_rdata_o    = rdata_q;
   assign pending_count_o   = pending_q;
   assign drop_full_count_o = drop_full_q;
   assign drop_bad_count_o  = drop_bad_q;
endmodule

// File: tb/tb_ethernet_rx_slot_buffer.sv
// tb_ethernet_rx_slot_buffer: directed table of frames with expected ring state, plus
// hand-written sequences for reads, in-order release, commit+ack overlap and mid-frame reset.
module tb_ethernet_rx_slot_buffer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tvalid, tready, tlast, tuser;
   logic        avail;
   logic [11:0] rsize;
   logic        rvalid;
   logic [10:0] raddr;
   logic [31:0] rdata;
   logic        ack;
   logic [2:0]  pending;
   logic [15:0] dfull, dbad;
   int          tests = 0;
   int          fails = 0;

   typedef struct {
      int nbytes;
      bit tuser;
      bit ack;
      int pend;
      int rsize;
      int full;
      int bad;
      int rd_id;
   } vec_t;
   vec_t vt [11];

   ethernet_rx_slot_buffer dut (
      .clk_i(clk), .reset_n_i(rst_n),
      .rx_axis_tdata_i(tdata), .rx_axis_tkeep_i(tkeep), .rx_axis_tvalid_i(tvalid),
      .rx_axis_tready_o(tready), .rx_axis_tlast_i(tlast), .rx_axis_tuser_i(tuser),
      .packet_avail_o(avail), .packet_rsize_o(rsize), .packet_rvalid_i(rvalid),
      .packet_raddr_i(raddr), .packet_rdata_o(rdata), .packet_ack_i(ack),
      .pending_count_o(pending), .drop_full_count_o(dfull), .drop_bad_count_o(dbad)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input int id, input int b);
      return {id[7:0], 8'hA5, b[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_frame(input int nbytes, input bit bad, input int id, input bit ack_last);
      int nb;
      int rem;
      logic [3:0] k;
      nb = (nbytes + 3) / 4;
      for (int b = 0; b < nb; b++) begin
         rem    = nbytes - 4 * b;
         k      = 4'hF;
         tkeep  = rem >= 4 ? k : k >> (4 - rem);
         tdata  = word_of(id, b);
         tlast  = (b == nb - 1);
         tuser  = tlast & bad;
         tvalid = 1'b1;
         ack    = ack_last & tlast;
         rvalid = ack_last & tlast;
         raddr  = '0;
         @(posedge clk); #1;
      end
      tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; ack = 1'b0; rvalid = 1'b0;
   endtask

   task automatic rd_check(input string name, input int addr, input logic [31:0] exp);
      rvalid = 1'b1;
      raddr  = 11'(addr);
      @(posedge clk); #1;
      rvalid = 1'b0;
      check(name, rdata, exp);
   endtask

   task automatic do_ack();
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, " tready"}, 32'(tready), 0);
      check({tag, " avail"}, 32'(avail), 0);
      check({tag, " rsize"}, 32'(rsize), 0);
      check({tag, " pending"}, 32'(pending), 0);
      check({tag, " drop_full"}, 32'(dfull), 0);
      check({tag, " drop_bad"}, 32'(dbad), 0);
      check({tag, " rdata"}, rdata, 0);
   endtask

   task automatic apply_vec(input int i);
      send_frame(vt[i].nbytes, vt[i].tuser, 20 + i, 1'b0);
      check($sformatf("v%0d pending", i), 32'(pending), 32'(vt[i].pend));
      check($sformatf("v%0d avail", i), 32'(avail), 32'(vt[i].pend != 0));
      check($sformatf("v%0d rsize", i), 32'(rsize), 32'(vt[i].rsize));
      check($sformatf("v%0d drop_full", i), 32'(dfull), 32'(vt[i].full));
      check($sformatf("v%0d drop_bad", i), 32'(dbad), 32'(vt[i].bad));
      if (vt[i].rd_id != 0) rd_check($sformatf("v%0d head word0", i), 0, word_of(vt[i].rd_id, 0));
      if (vt[i].ack) do_ack();
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0]  = '{64,   0, 0, 1, 64,   0, 0, 20};
      vt[1]  = '{64,   0, 0, 2, 64,   0, 0, 20};
      vt[2]  = '{64,   0, 0, 3, 64,   0, 0, 20};
      vt[3]  = '{64,   0, 0, 4, 64,   0, 0, 20};
      vt[4]  = '{64,   0, 0, 4, 64,   1, 0, 20};
      vt[5]  = '{61,   0, 1, 1, 61,   1, 0, 25};
      vt[6]  = '{2048, 0, 1, 1, 2048, 1, 0, 26};
      vt[7]  = '{2049, 0, 0, 0, 0,    1, 1, 0};
      vt[8]  = '{100,  1, 0, 0, 0,    1, 2, 0};
      vt[9]  = '{100,  0, 0, 1, 100,  1, 2, 29};
      vt[10] = '{3000, 0, 0, 1, 100,  1, 3, 29};
      rst_n = 1'b0; tdata = '0; tkeep = '0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
      rvalid = 1'b0; raddr = '0; ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("tready after release", 32'(tready), 1);

      send_frame(60, 1'b0, 1, 1'b0);
      check("f60 avail", 32'(avail), 1);
      check("f60 rsize", 32'(rsize), 60);
      for (int b = 0; b < 15; b++) rd_check($sformatf("f60 word%0d", b), 4 * b, word_of(1, b));
      do_ack();
      check("f60 avail after ack", 32'(avail), 0);
      check("f60 pending after ack", 32'(pending), 0);

      for (int i = 0; i < 5; i++) apply_vec(i);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("order%0d rsize", k), 32'(rsize), 64);
         rd_check($sformatf("order%0d word0", k), 0, word_of(20 + k, 0));
         rd_check($sformatf("order%0d word15", k), 60, word_of(20 + k, 15));
         do_ack();
      end
      check("order pending empty", 32'(pending), 0);
      for (int i = 5; i < 11; i++) apply_vec(i);

      send_frame(40, 1'b0, 50, 1'b1);
      check("overlap read old head", rdata, word_of(29, 0));
      check("overlap pending", 32'(pending), 1);
      check("overlap rsize", 32'(rsize), 40);
      rd_check("overlap new head", 0, word_of(50, 0));
      for (int k = 0; k < 10; k++) begin
         send_frame(4 * (k + 1), 1'b0, 60 + k, 1'b1);
         check($sformatf("wrap%0d old head", k), rdata, word_of(k == 0 ? 50 : 59 + k, 0));
         check($sformatf("wrap%0d pending", k), 32'(pending), 1);
         check($sformatf("wrap%0d rsize", k), 32'(rsize), 32'(4 * (k + 1)));
         rd_check($sformatf("wrap%0d word0", k), 0, word_of(60 + k, 0));
      end

      send_frame(16, 1'b0, 80, 1'b0);
      check("pre-reset pending", 32'(pending), 2);
      tvalid = 1'b1; tkeep = 4'hF; tlast = 1'b0;
      for (int b = 0; b < 3; b++) begin
         tdata = word_of(85, b);
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      tvalid = 1'b0;
      check_reset("midframe reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("tready after second release", 32'(tready), 1);
      send_frame(60, 1'b0, 90, 1'b0);
      check("post-reset pending", 32'(pending), 1);
      check("post-reset rsize", 32'(rsize), 60);
      rd_check("post-reset word0", 0, word_of(90, 0));
      rd_check("post-reset word14", 56, word_of(90, 14));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
